// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes a captured hex value onto a shared seven-segment bus
module ssd_scan_driver #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_W       = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   output logic [3:0]              hex,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    dp,
   output logic                    scan_tick
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [IW-1:0]           idx;
   logic [DIV_W-1:0]        cnt;
   logic [NUM_DIGITS:0]     zero_up;
   logic [3:0]              sel_hex;
   logic                    sel_dp;
   logic                    sel_blank;
   logic                    wrap;
   assign wrap = cnt == DIV_W'(REFRESH_DIV - 1);
   // zero_up[i] is set when nibbles i..NUM_DIGITS-1 of shadow are all zero
   always_comb begin
      zero_up = '0;
      zero_up[NUM_DIGITS] = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--)
         zero_up[i] = (shadow[4*i +: 4] == 4'h0) && zero_up[i+1];
   end
   always_comb begin
      sel_hex   = 4'h0;
      sel_dp    = 1'b0;
      sel_blank = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (idx == IW'(i)) begin
            sel_hex   = shadow[4*i +: 4];
            sel_dp    = dp_mask[i];
            sel_blank = blank_lz && (i != 0) && zero_up[i];
         end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow    <= '0;
         idx       <= '0;
         cnt       <= '0;
         scan_tick <= 1'b0;
         hex       <= 4'h0;
         an        <= '1;
         dp        <= 1'b1;
      end else begin
         if (load) shadow <= value;
         cnt       <= wrap ? '0 : cnt + 1'b1;
         idx       <= !wrap ? idx : (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         scan_tick <= wrap;
         hex       <= sel_hex;
         an        <= sel_blank ? '1 : ~(NUM_DIGITS'(1) << idx);
         dp        <= sel_blank ? 1'b1 : ~sel_dp;
      end
   end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: scoreboard bench for ssd_scan_driver (4 digits, REFRESH_DIV 3 and 1)
module tb_ssd_scan_driver;
   logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp_mask = 4'h0;
   logic [3:0]  hex, an, hex_b, an_b, an_exp;
   logic        dp, scan_tick, dp_b, scan_tick_b;
   int          tests = 0, fails = 0;
   typedef struct packed {
      logic [3:0] hex;
      logic [3:0] an;
      logic       dp;
      logic       tick;
   } exp_t;
   exp_t        q[$];
   logic [15:0] m_shadow = 16'h0;
   int          m_idx = 0, m_cnt = 0;

   always #5 clk = ~clk;

   ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3), .DIV_W(2)) dut (
      .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .hex(hex), .an(an), .dp(dp), .scan_tick(scan_tick));

   ssd_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(1), .DIV_W(1)) dut_b (
      .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
      .dp_mask(dp_mask), .hex(hex_b), .an(an_b), .dp(dp_b), .scan_tick(scan_tick_b));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // predict the outputs of the coming edge, advance the model, then compare after the edge
   task automatic step();
      exp_t e;
      logic blk;
      if (rst) begin
         e = '{hex: 4'h0, an: 4'hF, dp: 1'b1, tick: 1'b0};
         m_shadow = 16'h0;
         m_idx = 0;
         m_cnt = 0;
      end else begin
         blk = blank_lz && m_idx != 0 && ((m_shadow >> (4 * m_idx)) == 16'h0);
         e.hex  = m_shadow[4*m_idx +: 4];
         e.an   = blk ? 4'hF : ~(4'b0001 << m_idx);
         e.dp   = blk ? 1'b1 : ~dp_mask[m_idx];
         e.tick = (m_cnt == 2);
         if (load) m_shadow = value;
         if (m_cnt == 2) begin
            m_cnt = 0;
            m_idx = (m_idx == 3) ? 0 : m_idx + 1;
         end else m_cnt++;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("hex", hex, e.hex);
      chk("an", an, e.an);
      chk("dp", dp, e.dp);
      chk("tick", scan_tick, e.tick);
      chk("onecold", $countones(~an) <= 1, 1);
   endtask

   task automatic wait_digit2();
      for (int i = 0; i < 20 && !(m_idx == 2 && m_cnt == 1); i++) step();
      chk("wait_d2", (m_idx == 2 && m_cnt == 1), 1);
   endtask

   initial begin
      step();
      step();
      chk("rst_an", an, 4'hF);
      chk("rst_hex", hex, 4'h0);
      chk("rst_dp", dp, 1'b1);
      chk("rst_tick", scan_tick, 1'b0);
      rst = 1'b0;
      value = 16'h1234; load = 1'b1; step(); load = 1'b0;
      repeat (14) step();
      blank_lz = 1'b1;
      value = 16'h00A0; load = 1'b1; step(); load = 1'b0;
      repeat (13) step();
      value = 16'h0000; load = 1'b1; step(); load = 1'b0;
      repeat (13) step();
      blank_lz = 1'b0;
      repeat (12) step();
      value = 16'h1234; load = 1'b1; step(); load = 1'b0;
      wait_digit2();
      value = 16'hBEEF; load = 1'b1; step(); load = 1'b0;
      chk("mid_load_old", hex, 4'h2);
      step();
      chk("mid_load_new", hex, 4'hE);
      repeat (6) step();
      dp_mask = 4'b0100;
      repeat (12) step();
      blank_lz = 1'b1;
      value = 16'h0005; load = 1'b1; step(); load = 1'b0;
      repeat (12) step();
      blank_lz = 1'b0;
      value = 16'h1234; load = 1'b1; step(); load = 1'b0;
      wait_digit2();
      rst = 1'b1; step(); rst = 1'b0;
      chk("midrst_an", an, 4'hF);
      chk("midrst_hex", hex, 4'h0);
      repeat (12) step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("b_rst_an", an_b, 4'hF);
      chk("b_rst_tick", scan_tick_b, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step();
         an_exp = ~(4'b0001 << (i % 4));
         chk("b_tick", scan_tick_b, 1'b1);
         chk("b_an", an_b, an_exp);
         chk("b_hex", hex_b, 4'h0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Time-multiplexes a multi-digit hex value onto a shared seven-segment bus, one digit at a time.
- Sits directly upstream of the hex-to-segment decoder. Its hex output feeds the decoder's 4-bit input; its an output drives the common-anode digit enables.
- Typical use is displaying a processor register, PC or writeback value on the board display.
- Provides tear-free capture, a programmable refresh rate and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (legal 1..8).
- REFRESH_DIV, 100000, clk cycles each digit is held (legal >= 1).
- DIV_W, 17, width of the refresh counter; must satisfy 2^DIV_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- value  input  4*NUM_DIGITS  value to display; nibble i maps to digit i (digit 0 is rightmost, least significant).
- load  input  1  when 1 at a clk edge, value is captured into the shadow register.
- blank_lz  input  1  enables leading-zero blanking.
- dp_mask  input  NUM_DIGITS  per-digit decimal-point request, active-high.
- hex  output  4  nibble for the active digit, to the decoder.
- an  output  NUM_DIGITS  digit enables, active-low, one-cold.
- dp  output  1  decimal point for the active digit, active-low.
- scan_tick  output  1  one-cycle pulse on the cycle the digit index advances.

Behaviour:
- Clock, reset and priority
  - One clock: clk. Reset is synchronous and active-high: rst, sampled on the rising edge of clk.
  - rst has priority over load and over scanning.
- Reset values
  - shadow = 0, idx = 0, cnt = 0.
  - hex = 4'h0, an = all ones (all digits off), dp = 1, scan_tick = 0.
- Shadow register
  - On an edge with load = 1 and rst = 0, shadow <= value.
  - Otherwise shadow holds. The display reads only shadow, never value directly.
- Refresh counter cnt
  - If cnt == REFRESH_DIV-1: cnt <= 0, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1, scan_tick <= 1.
  - Otherwise: cnt <= cnt+1, scan_tick <= 0.
  - With REFRESH_DIV = 1, idx advances every cycle and scan_tick is held at 1.
- Output registers
  - hex, an and dp are updated every cycle from the current idx, shadow, dp_mask and blank_lz.
  - This gives 1-cycle latency: outputs reflect the idx and shadow values present at the previous edge.
  - hex <= shadow[4*idx +: 4].
  - an <= ~(1 << idx) unless the digit is blanked, in which case an <= all ones.
  - dp <= ~dp_mask[idx] unless the digit is blanked, in which case dp <= 1.
- Leading-zero blanking
  - Digit i is blanked iff blank_lz = 1, i != 0, and shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blanking affects only an and dp; hex is still driven.
- Mid-scan events
  - load mid-scan changes neither cnt nor idx; the new nibble appears on the next output update.
  - rst mid-scan forces the reset values on the next edge. Scanning restarts at digit 0 with a full REFRESH_DIV hold.
- Output cleanliness
  - an is never more than one digit low.
  - No output glitches: all outputs come straight from flops.
- Combinational paths
  - value and dp_mask have no combinational path to any output.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=3 unless stated):
- Reset then free-run with value=16'h1234 loaded once -> idx sequence 0,1,2,3,0 with a step every 3 cycles. (hex, an) pairs: (4,1110), (3,1101), (2,1011), (1,0111). scan_tick pulses once per step.
- blank_lz=1, load 16'h00A0 -> digits 3 and 2 show an=1111. Digit 1 gives hex=A, an=1101. Digit 0 gives hex=0, an=1110.
- blank_lz=1, load 16'h0000 -> only digit 0 is lit with hex=0; digits 1..3 give an=1111. blank_lz=0 lights all four with 0.
- load=1 with value=16'hBEEF in the same cycle idx=2 is displayed, previous shadow 16'h1234 -> the current digit-2 window shows 2 before the edge and E on the output update after the edge. cnt and idx are unaffected.
- dp_mask=4'b0100 -> dp=0 only while an=1011. dp=1 elsewhere and while blanked.
- Assert rst for 1 cycle mid-digit-2 -> next edge gives an=1111, hex=0, shadow=0. Digit 0 is then held for exactly 3 cycles. Repeat with REFRESH_DIV=1: idx steps every cycle and scan_tick stays at 1 after reset.
